stw_result_mapper: RTL

STW_RESULT_MAPPER -- requirements
Module: stw_result_mapper

---
 rtl/stw_result_mapper.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/stw_result_mapper.sv
// Stationary-weight test sequencer: drives one row at a time, records per-PE pass bits, then maps a proxy row per column.
// Optional STW_FAULT_INJECT_EN adds fault_inject_mask, which forces listed PEs to fail during capture.
module stw_result_mapper #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int TEST_LAT  = ROWS + 1,
    localparam int ROW_WIDTH = $clog2(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic [COLS*WORD_SIZE-1:0] stw_col_out,
    input  logic [WORD_SIZE-1:0]      stw_expected,
`ifdef STW_FAULT_INJECT_EN
    input  logic [COLS*ROWS-1:0]      fault_inject_mask,
`endif
    output logic                      stw_test_en,
    output logic [ROW_WIDTH-1:0]      stw_row_sel,
    output logic                      STW_complete,
    output logic [COLS*ROWS-1:0]      STW_result_mat,
    output logic [COLS*ROW_WIDTH-1:0] proxy_row_idx,
    output logic [COLS-1:0]           unrepairable,
    output logic                      proxy_map_done
);

    localparam int CNT_W = (TEST_LAT > 1) ? $clog2(TEST_LAT) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CAPTURE,
        MAP,
        DONE
    } state_t;

    state_t state, next_state;

    logic [ROW_WIDTH-1:0] row;
    logic [CNT_W-1:0]     wait_cnt;
    logic [COL_W-1:0]     map_col;
    logic [COLS*ROWS-1:0] inj_mask;
    logic [COLS*ROWS-1:0] capture_fail;
    logic [COLS-1:0]      col_mismatch;
    logic [ROWS-1:0]      map_bits;
    logic [ROW_WIDTH-1:0] map_proxy;
    logic                 map_any;
    logic                 last_row;
    logic                 last_wait;
    logic                 last_col;
    logic                 accept_start;

`ifdef STW_FAULT_INJECT_EN
    assign inj_mask = fault_inject_mask;
`else
    assign inj_mask = '0;
`endif

    assign last_row     = (row == ROW_WIDTH'(ROWS - 1));
    assign last_wait    = (wait_cnt == CNT_W'(TEST_LAT - 1));
    assign last_col     = (map_col == COL_W'(COLS - 1));
    assign accept_start = start && ((state == IDLE) || (state == DONE));
    assign stw_row_sel  = row;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        stw_test_en = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) next_state = DRIVE;
            end
            DRIVE: begin
                if (!stall) begin
                    stw_test_en = 1'b1;
                    next_state  = WAIT;
                end
            end
            WAIT: begin
                if (!stall && last_wait) next_state = CAPTURE;
            end
            CAPTURE: begin
                if (!stall) next_state = last_row ? MAP : DRIVE;
            end
            MAP: begin
                if (last_col) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Per-PE fail vector for the row under test; only the selected row's bits can be set.
    always_comb begin
        col_mismatch = '0;
        capture_fail = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            col_mismatch[c] = (stw_col_out[c*WORD_SIZE +: WORD_SIZE] != stw_expected);
            for (int unsigned r = 0; r < ROWS; r++) begin
                capture_fail[c*ROWS + r] = (row == ROW_WIDTH'(r)) &&
                                           (col_mismatch[c] || inj_mask[c*ROWS + r]);
            end
        end
    end

    // Highest-index passing row of the column currently being mapped.
    always_comb begin
        map_bits  = '0;
        map_proxy = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (map_col == COL_W'(c)) map_bits = STW_result_mat[c*ROWS +: ROWS];
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (map_bits[r]) map_proxy = ROW_WIDTH'(r);
        end
        map_any = |map_bits;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row            <= '0;
            wait_cnt       <= '0;
            map_col        <= '0;
            STW_complete   <= 1'b0;
            STW_result_mat <= '1;
            proxy_row_idx  <= '0;
            unrepairable   <= '0;
            proxy_map_done <= 1'b0;
        end else begin
            if (accept_start) begin
                row            <= '0;
                wait_cnt       <= '0;
                map_col        <= '0;
                STW_complete   <= 1'b0;
                STW_result_mat <= '1;
                unrepairable   <= '0;
                proxy_map_done <= 1'b0;
            end else begin
                case (state)
                    DRIVE: begin
                        if (!stall) wait_cnt <= '0;
                    end
                    WAIT: begin
                        if (!stall) wait_cnt <= wait_cnt + 1'b1;
                    end
                    CAPTURE: begin
                        if (!stall) begin
                            STW_result_mat <= STW_result_mat & ~capture_fail;
                            if (last_row) begin
                                STW_complete <= 1'b1;
                                map_col      <= '0;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end
                    end
                    MAP: begin
                        for (int unsigned c = 0; c < COLS; c++) begin
                            if (map_col == COL_W'(c)) begin
                                proxy_row_idx[c*ROW_WIDTH +: ROW_WIDTH] <= map_any ? map_proxy : '0;
                                unrepairable[c]                         <= ~map_any;
                            end
                        end
                        map_col <= map_col + 1'b1;
                        if (last_col) proxy_map_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
